// File: rtl/key_evt_ctrl.sv
// key_evt_ctrl: classifies debounced key press/release pulses into short, double and long events
module key_evt_ctrl #(
  parameter int unsigned CNT_LONG = 49_999_999,
  parameter int unsigned CNT_DBL  = 14_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic       key_release,
  output logic       short_flag,
  output logic       double_flag,
  output logic       long_flag,
  output logic       busy,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, PRESS1 = 3'd1, WAIT2 = 3'd2, PRESS2 = 3'd3, HOLD = 3'd4} state_t;
  localparam logic [31:0] LONG_M1 = 32'(CNT_LONG - 1);
  localparam logic [31:0] DBL_M1  = 32'(CNT_DBL - 1);
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        short_q, short_d, double_q, double_d, long_q, long_d;
  logic        prs, rel;
  always_comb begin
    prs      = key_press & ~key_release;
    rel      = key_release & ~key_press;
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE:    state_d = prs ? PRESS1 : IDLE;
      PRESS1: begin
        if (rel) state_d = WAIT2;
        else if (cnt_q == LONG_M1) begin
          state_d = HOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (prs) state_d = PRESS2;
        else if (cnt_q == DBL_M1) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (rel) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (cnt_q == LONG_M1) begin
          state_d  = HOLD;
          double_d = 1'b1;
        end
      end
      HOLD:    state_d = rel ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end
  assign short_flag  = short_q;
  assign double_flag = double_q;
  assign long_flag   = long_q;
  assign busy        = (state_q != IDLE);
  assign state       = state_q;
endmodule

// File: doc/key_evt_ctrl.md
KEY_EVT_CTRL -- requirements
Module: key_evt_ctrl

Interface
REQ-001 SHALL provide parameter CNT_LONG, default 49_999_999, hold time in clk cycles that classifies a press as long (1 s at 50 MHz).
REQ-002 SHALL provide parameter CNT_DBL, default 14_999_999, window in clk cycles after a release in which a second press forms a double click (300 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port key_press  input  1  one-cycle pulse from the upstream debouncer on a debounced press.
REQ-006 SHALL have port key_release  input  1  one-cycle pulse from the upstream debouncer on a debounced release.
REQ-007 SHALL have port short_flag  output  1  one-cycle pulse, single short click classified.
REQ-008 SHALL have port double_flag  output  1  one-cycle pulse, double click classified.
REQ-009 SHALL have port long_flag  output  1  one-cycle pulse, long press classified.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port state  output  3  current FSM state encoding: IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, HOLD=4.

Function
REQ-012 SHALL implement FSM states IDLE, PRESS1, WAIT2, PRESS2 and HOLD, with a 32-bit cycle counter cnt that clears to 0 on every state transition and increments by 1 every cycle otherwise.
REQ-013 In IDLE, a sampled key_press SHALL move the FSM to PRESS1; key_release SHALL be ignored.
REQ-014 In PRESS1, a sampled key_release SHALL move the FSM to WAIT2; when cnt == CNT_LONG-1 with no release that cycle, the FSM SHALL move to HOLD and pulse long_flag.
REQ-015 In WAIT2, a sampled key_press SHALL move the FSM to PRESS2; when cnt == CNT_DBL-1 with no press that cycle, the FSM SHALL move to IDLE and pulse short_flag.
REQ-016 In PRESS2, a sampled key_release SHALL move the FSM to IDLE and pulse double_flag.
REQ-017 In PRESS2, when cnt == CNT_LONG-1 with no release that cycle, the FSM SHALL move to HOLD and pulse double_flag; long_flag SHALL NOT pulse.
REQ-018 In HOLD, a sampled key_release SHALL move the FSM to IDLE with no output pulse.
REQ-019 Every output pulse SHALL be registered and high for exactly 1 cycle, in the cycle after the deciding condition is sampled.
REQ-020 Long timing: with key_press sampled at cycle T and no release in T+1..T+CNT_LONG, long_flag SHALL be high in cycle T+CNT_LONG+1.
REQ-021 Short timing: with the first key_release sampled at cycle R and no press in R+1..R+CNT_DBL, short_flag SHALL be high in cycle R+CNT_DBL+1.
REQ-022 Double timing: with the second key_release sampled at cycle R2, double_flag SHALL be high in cycle R2+1.
REQ-023 If key_press and key_release are both high in the same cycle, both SHALL be ignored: no transition, and cnt behaves as if neither were asserted.
REQ-024 key_press in PRESS1, PRESS2 or HOLD SHALL be ignored; key_release in IDLE or WAIT2 SHALL be ignored.
REQ-025 A timeout compare and an event in the same cycle SHALL resolve in favour of the event: release in PRESS1 goes to WAIT2, press in WAIT2 goes to PRESS2.
REQ-026 At most one of short_flag, double_flag and long_flag SHALL be high in any cycle.
REQ-027 busy SHALL equal (state != IDLE) combinationally from the state register.

Reset
REQ-028 While rst is high at a clock edge, the FSM SHALL enter IDLE, cnt SHALL be 0, short_flag, double_flag and long_flag SHALL be 0, and busy SHALL be 0.
REQ-029 rst asserted mid-sequence (any state) SHALL abort the sequence with no pending pulse emitted; pulses within the reset cycle SHALL be ignored.
REQ-030 After rst deasserts, the first key_press sampled SHALL start a fresh sequence from IDLE.

Verification (bench uses CNT_LONG=20, CNT_DBL=10)
REQ-031 SHALL cover: press at T=5, release at T=10 -> state goes 1 then 2; short_flag high only at cycle 21; no other flags.
REQ-032 SHALL cover: press at T=5, held -> long_flag high only at cycle 26, state=4; release at T=40 -> state=0, no further pulse.
REQ-033 SHALL cover: press 5, release 8, press 12, release 15 -> double_flag high only at cycle 16; short_flag never high.
REQ-034 SHALL cover: press 5, release 8, press 12, held -> double_flag at cycle 33, state=4, long_flag never high.
REQ-035 SHALL cover: press and release together at T=5 in IDLE -> state stays 0; separately, release exactly at the PRESS1 timeout cycle (T=25 for press at 5) -> WAIT2 with no long_flag.
REQ-036 SHALL cover: rst pulsed at T=9 during WAIT2 -> state=0, busy=0, no short_flag ever emitted; the next press restarts in PRESS1.
